// File: rtl/jump_monitor_pkg.sv
// jump_monitor_pkg: shared state encoding and constants for the jump monitor.
//   COUNT_W      width of the upstream counter samples
//   LOCK_LEN_DEF default number of consecutive +1 steps needed to lock
//   state_t      monitor FSM states
package jump_monitor_pkg;
    localparam int COUNT_W = 4;
    localparam int LOCK_LEN_DEF = 4;
    typedef enum logic [1:0] {ACQUIRE, HUNT, LOCKED} state_t;
endpackage

// File: rtl/jump_monitor_sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear (clear beats increment).
//   clk, reset  clock and synchronous active-high reset
//   inc         increment request
//   clr         synchronous clear, higher priority than inc
//   count       current value, sticks at all-ones
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);
    always_ff @(posedge clk)
        if (reset || clr) count <= '0;
        else if (inc && count != '1) count <= count + 1'b1;
endmodule

// File: rtl/jump_monitor.sv
// jump_monitor: watches a 4-bit counter stream, tracks lock on +1 steps and flags jumps.
//   clk, reset   clock and synchronous active-high reset
//   count_in     upstream counter sample, valid when sample_en=1
//   sample_en    sample qualifier
//   clear        clears jump_total and jump_seen only
//   jump_pulse   one-cycle pulse, registered, the cycle after a jump is sampled
//   jump_from    previous sample at the most recent jump
//   jump_to      offending sample at the most recent jump
//   jump_total   saturating jump count
//   in_lock      high while locked
//   jump_seen    sticky flag set by a jump, cleared by clear or reset
module jump_monitor
    import jump_monitor_pkg::*;
#(
    parameter int LOCK_LEN = LOCK_LEN_DEF,
    parameter int TOT_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [COUNT_W-1:0] count_in,
    input  logic               sample_en,
    input  logic               clear,
    output logic               jump_pulse,
    output logic [COUNT_W-1:0] jump_from,
    output logic [COUNT_W-1:0] jump_to,
    output logic [TOT_W-1:0]   jump_total,
    output logic               in_lock,
    output logic               jump_seen
);
    state_t state, state_n;
    logic [COUNT_W-1:0] prev, prev_n;
    logic [3:0] run, run_n;
    logic step, hold, jump_det;
    always_comb begin
        step = count_in == COUNT_W'(prev + 1'b1);
        hold = count_in == prev;
        state_n = state;
        run_n = run;
        prev_n = prev;
        jump_det = 1'b0;
        if (sample_en) begin
            prev_n = count_in;
            case (state)
                ACQUIRE: begin
                    run_n = '0;
                    state_n = HUNT;
                end
                HUNT: begin
                    if (step) begin
                        run_n = run + 4'd1;
                        state_n = (run_n == 4'(LOCK_LEN)) ? LOCKED : HUNT;
                    end else if (!hold) begin
                        jump_det = 1'b1;
                        run_n = '0;
                    end
                end
                LOCKED: begin
                    if (!step && !hold) begin
                        jump_det = 1'b1;
                        run_n = '0;
                        state_n = HUNT;
                    end
                end
                default: state_n = ACQUIRE;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ACQUIRE;
            run <= '0;
            prev <= '0;
            jump_pulse <= 1'b0;
            jump_from <= '0;
            jump_to <= '0;
            jump_seen <= 1'b0;
        end else begin
            state <= state_n;
            run <= run_n;
            prev <= prev_n;
            jump_pulse <= jump_det;
            if (jump_det) begin
                jump_from <= prev;
                jump_to <= count_in;
            end
            // clear wins over a simultaneous jump
            if (clear) jump_seen <= 1'b0;
            else if (jump_det) jump_seen <= 1'b1;
        end
    end
    assign in_lock = state == LOCKED;
    sat_counter #(.W(TOT_W)) u_total (
        .clk(clk),
        .reset(reset),
        .inc(jump_det),
        .clr(clear),
        .count(jump_total)
    );
endmodule

// File: tb/tb_jump_monitor.sv
// tb_jump_monitor: table vectors, directed corner sequences and random stimulus vs a reference model.
module tb_jump_monitor;
    logic clk = 0, reset = 1, sample_en = 0, clear = 0;
    logic [3:0] count_in = 0;
    logic a_pulse, b_pulse, a_lock, b_lock, a_seen, b_seen;
    logic [3:0] a_from, a_to, b_from, b_to;
    logic [7:0] a_tot;
    logic [1:0] b_tot;
    int n_cmp = 0, n_fail = 0;

    always #5 clk = ~clk;

    jump_monitor u_dut (
        .clk(clk), .reset(reset), .count_in(count_in), .sample_en(sample_en), .clear(clear),
        .jump_pulse(a_pulse), .jump_from(a_from), .jump_to(a_to), .jump_total(a_tot),
        .in_lock(a_lock), .jump_seen(a_seen)
    );

    jump_monitor #(.LOCK_LEN(4), .TOT_W(2)) u_sat (
        .clk(clk), .reset(reset), .count_in(count_in), .sample_en(sample_en), .clear(clear),
        .jump_pulse(b_pulse), .jump_from(b_from), .jump_to(b_to), .jump_total(b_tot),
        .in_lock(b_lock), .jump_seen(b_seen)
    );

    // reference model: mode 0=acquiring, 1=hunting, 2=locked
    int m_mode = 0, m_prev = 0, m_run = 0, m_from = 0, m_to = 0, m_tot8 = 0, m_tot2 = 0;
    bit m_pulse = 0, m_seen = 0;

    task automatic model(input bit r, input bit en, input bit cl, input int v);
        int d;
        if (r) begin
            m_mode = 0; m_prev = 0; m_run = 0; m_from = 0; m_to = 0;
            m_tot8 = 0; m_tot2 = 0; m_pulse = 0; m_seen = 0;
            return;
        end
        m_pulse = 0;
        if (en) begin
            if (m_mode == 0) begin
                m_mode = 1; m_run = 0;
            end else begin
                d = (v - m_prev + 16) % 16;
                if (d > 1) begin
                    m_pulse = 1; m_from = m_prev; m_to = v; m_seen = 1;
                    m_tot8 = (m_tot8 < 255) ? m_tot8 + 1 : 255;
                    m_tot2 = (m_tot2 < 3) ? m_tot2 + 1 : 3;
                    m_run = 0; m_mode = 1;
                end else if (d == 1 && m_mode == 1) begin
                    m_run++;
                    if (m_run == 4) m_mode = 2;
                end
            end
            m_prev = v;
        end
        if (cl) begin
            m_tot8 = 0; m_tot2 = 0; m_seen = 0;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("pulse", 32'(a_pulse), 32'(m_pulse));
        chk("from", 32'(a_from), 32'(m_from));
        chk("to", 32'(a_to), 32'(m_to));
        chk("total", 32'(a_tot), 32'(m_tot8));
        chk("lock", 32'(a_lock), 32'(m_mode == 2));
        chk("seen", 32'(a_seen), 32'(m_seen));
        chk("sat_pulse", 32'(b_pulse), 32'(m_pulse));
        chk("sat_to", 32'(b_to), 32'(m_to));
        chk("sat_total", 32'(b_tot), 32'(m_tot2));
        chk("sat_seen", 32'(b_seen), 32'(m_seen));
    endtask

    task automatic drive(input bit r, input bit en, input bit cl, input int v);
        reset = r; sample_en = en; clear = cl; count_in = 4'(v);
        @(posedge clk);
        model(r, en, cl, v);
        #1;
        check_model();
    endtask

    typedef struct {
        bit rst, en, clr;
        int v;
        bit pulse;
        int from, to, tot;
        bit lock, seen;
    } vec_t;
    vec_t tbl[17];

    initial begin
        int npulse, last;
        tbl[0]  = '{1, 0, 0, 0,  0, 0, 0, 0, 0, 0};
        tbl[1]  = '{0, 1, 0, 3,  0, 0, 0, 0, 0, 0};
        tbl[2]  = '{0, 1, 0, 4,  0, 0, 0, 0, 0, 0};
        tbl[3]  = '{0, 1, 0, 5,  0, 0, 0, 0, 0, 0};
        tbl[4]  = '{0, 1, 0, 6,  0, 0, 0, 0, 0, 0};
        tbl[5]  = '{0, 1, 0, 7,  0, 0, 0, 0, 1, 0};
        tbl[6]  = '{0, 1, 0, 12, 1, 7, 12, 1, 0, 1};
        tbl[7]  = '{0, 0, 0, 9,  0, 7, 12, 1, 0, 1};
        tbl[8]  = '{0, 1, 0, 13, 0, 7, 12, 1, 0, 1};
        tbl[9]  = '{1, 1, 1, 5,  0, 0, 0, 0, 0, 0};
        tbl[10] = '{0, 1, 0, 2,  0, 0, 0, 0, 0, 0};
        tbl[11] = '{0, 1, 0, 3,  0, 0, 0, 0, 0, 0};
        tbl[12] = '{0, 0, 0, 9,  0, 0, 0, 0, 0, 0};
        tbl[13] = '{0, 1, 0, 3,  0, 0, 0, 0, 0, 0};
        tbl[14] = '{0, 1, 0, 4,  0, 0, 0, 0, 0, 0};
        tbl[15] = '{0, 1, 0, 5,  0, 0, 0, 0, 0, 0};
        tbl[16] = '{0, 1, 0, 6,  0, 0, 0, 0, 1, 0};
        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].rst, tbl[i].en, tbl[i].clr, tbl[i].v);
            chk($sformatf("tbl%0d_pulse", i), 32'(a_pulse), 32'(tbl[i].pulse));
            chk($sformatf("tbl%0d_from", i), 32'(a_from), 32'(tbl[i].from));
            chk($sformatf("tbl%0d_to", i), 32'(a_to), 32'(tbl[i].to));
            chk($sformatf("tbl%0d_total", i), 32'(a_tot), 32'(tbl[i].tot));
            chk($sformatf("tbl%0d_lock", i), 32'(a_lock), 32'(tbl[i].lock));
            chk($sformatf("tbl%0d_seen", i), 32'(a_seen), 32'(tbl[i].seen));
        end

        // clean ramp with 15->0 wrap
        drive(1, 0, 0, 0);
        drive(1, 0, 0, 0);
        npulse = 0;
        for (int i = 0; i < 18; i++) begin
            drive(0, 1, 0, i % 16);
            npulse += int'(a_pulse);
            if (i == 3) chk("ramp_prelock", 32'(a_lock), 0);
            if (i == 4) chk("ramp_lock", 32'(a_lock), 1);
        end
        chk("ramp_pulses", 32'(npulse), 0);
        chk("ramp_total", 32'(a_tot), 0);

        // saturation of the 2-bit total, then clear colliding with a jump
        drive(1, 0, 0, 0);
        drive(0, 1, 0, 0);
        npulse = 0;
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 0, (i % 2 == 0) ? 8 : 0);
            npulse += int'(b_pulse);
        end
        chk("sat_pulses", 32'(npulse), 5);
        chk("sat_tot3", 32'(b_tot), 3);
        drive(0, 1, 1, 3);
        chk("clr_jump_pulse", 32'(b_pulse), 1);
        chk("clr_jump_total", 32'(b_tot), 0);
        chk("clr_jump_seen", 32'(b_seen), 0);
        chk("clr_jump_to", 32'(b_to), 3);

        // reset while locked discards history
        drive(1, 0, 0, 0);
        for (int i = 0; i <= 9; i++) drive(0, 1, 0, i);
        chk("pre_reset_lock", 32'(a_lock), 1);
        drive(1, 1, 0, 9);
        drive(0, 1, 0, 4);
        chk("post_reset_pulse", 32'(a_pulse), 0);
        chk("post_reset_lock", 32'(a_lock), 0);
        chk("post_reset_total", 32'(a_tot), 0);
        drive(0, 1, 0, 9);
        chk("post_reset_hunt_jump", 32'(a_pulse), 1);

        // random traffic
        last = 0;
        for (int i = 0; i < 3000; i++) begin
            int r, v;
            r = int'($urandom_range(0, 99));
            v = (r < 55) ? (last + 1) % 16 : (r < 70) ? last : int'($urandom_range(0, 15));
            last = v;
            drive($urandom_range(0, 99) == 0, $urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0, v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/jump_monitor.md
JUMP_MONITOR -- requirements
Module: jump_monitor

Interface
REQ-001 Parameter LOCK_LEN, default 4: consecutive +1 steps required to declare lock, range 1..15.
REQ-002 Parameter TOT_W, default 8: width of the jump_total counter.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  reset is synchronous and active-high; there is one clock.
REQ-005 Port count_in  input  4  sample from the upstream 4-bit jump counter.
REQ-006 Port sample_en  input  1  count_in is evaluated only in cycles where sample_en=1.
REQ-007 Port clear  input  1  synchronous clear of jump_total and the sticky flag only.
REQ-008 Port jump_pulse  output  1  one-cycle pulse when a jump is detected.
REQ-009 Port jump_from  output  4  previous sample at the most recent jump.
REQ-010 Port jump_to  output  4  offending sample at the most recent jump.
REQ-011 Port jump_total  output  TOT_W  number of jumps, saturating.
REQ-012 Port in_lock  output  1  high while the FSM is in LOCKED.
REQ-013 Port jump_seen  output  1  sticky flag, set on the first jump and held until clear or reset.

Function
REQ-014 A sample whose value equals (prev+1) mod 16 shall be a step; 15->0 shall be a step, not a jump.
REQ-015 A sample equal to prev shall be a hold: neither a step nor a jump, with run length unchanged.
REQ-016 Any other sample shall be a jump.
REQ-017 The FSM shall have states ACQUIRE, HUNT and LOCKED.
REQ-018 ACQUIRE behaviour: the first enabled sample shall be stored as prev, run=0, next state HUNT; jump detection shall be suppressed.
REQ-019 HUNT, step: run shall increment, and the FSM shall enter LOCKED when run reaches LOCK_LEN.
REQ-020 HUNT, jump: the FSM shall stay in HUNT with run=0.
REQ-021 LOCKED, step or hold: the FSM shall stay in LOCKED.
REQ-022 LOCKED, jump: the FSM shall go to HUNT with run=0.
REQ-023 On every enabled sample after ACQUIRE, prev shall be updated to count_in.
REQ-024 Jump latency: jump_pulse, jump_from, jump_to and the jump_total increment shall all be registered and take effect in the cycle after the sampling edge (latency 1).
REQ-025 jump_from and jump_to shall hold their values until the next jump.
REQ-026 When sample_en=0, the FSM, run, prev and jump_total shall be frozen, and jump_pulse shall be 0 in the following cycle.
REQ-027 jump_total shall saturate at 2^TOT_W-1, and further jumps shall still pulse jump_pulse.
REQ-028 If clear and a jump occur in the same cycle, clear shall win: jump_total=0 and jump_seen=0. jump_pulse, jump_from and jump_to shall still update.
REQ-029 clear shall not affect the FSM, run, prev or in_lock.

Reset
REQ-030 On reset=1 at a clock edge, the next state shall be: state ACQUIRE, run=0, prev=0, jump_pulse=0, jump_from=0, jump_to=0, jump_total=0, in_lock=0, jump_seen=0.
REQ-031 Reset shall override sample_en and clear.
REQ-032 A reset asserted mid-run shall discard history: the first sample after release re-enters via ACQUIRE with no jump flagged.

Structure
REQ-033 Package jump_monitor_pkg shall hold the state enum (ACQUIRE/HUNT/LOCKED), the COUNT_W=4 constant and the default LOCK_LEN.
REQ-034 Sub-module sat_counter (parameterised width, inc, clr, clr priority) shall implement jump_total.
REQ-035 The FSM and step/jump classification shall be implemented in jump_monitor itself.

Verification
REQ-036 Clean ramp: reset 2 cycles, then count_in 0,1,...,15,0,1 with sample_en=1 -> in_lock=1 from the cycle after the 5th sample, jump_pulse never asserted, jump_total=0.
REQ-037 Jump while locked: sequence 3,4,5,6,7,12 -> jump_pulse=1 for one cycle after 12, jump_from=7, jump_to=12, jump_total=1, jump_seen=1, in_lock falls to 0 in the same cycle.
REQ-038 Hold and enable: sequence 2,3,3,4 with a sample_en=0 gap carrying count_in=9 -> no jump, run reaches 2.
REQ-039 Saturation and clear: TOT_W=2, 5 jumps -> jump_total=3 and 5 pulses; clear asserted together with a 6th jump -> jump_total=0, jump_seen=0, jump_to updated.
REQ-040 Reset mid-run: in LOCKED at value 9, reset for 1 cycle, then sample 4 -> no jump_pulse, state HUNT, all outputs 0 except in_lock=0.
